// File: rtl/base_afilter_reg.sv
// Registered valid/ready filter stage with a 2-entry skid buffer; beats with i_en=0 are dropped.
// Optional saturating drop counter enabled by defining BASE_AFILTER_REG_DROPCNT_EN.
module base_afilter_reg #(
    parameter int unsigned width = 8,
    parameter int unsigned cntw  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_v,
    output logic               i_r,
    input  logic [0:width-1]   i_d,
    input  logic               i_en,
    output logic               o_v,
    input  logic               o_r,
    output logic [0:width-1]   o_d,
    output logic               o_drop,
    input  logic               i_drop_clr,
    output logic [cntw-1:0]    o_drop_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q;
    logic [0:width-1] main_q;
    logic [0:width-1] skid_q;
    logic             ready_q;
    logic             drop_q;

    logic acc;
    logic enq;
    logic dis;
    logic deq;

    assign acc = i_v & ready_q;
    assign enq = acc & i_en;
    assign dis = acc & ~i_en;
    assign deq = (state_q != StEmpty) & o_r;

    // ready_q tracks the next state so i_r never depends combinationally on o_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q  <= dis;
            ready_q <= 1'b1;
            case (state_q)
                StEmpty: begin
                    if (enq) begin
                        main_q  <= i_d;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (enq && deq) begin
                        main_q <= i_d;
                    end else if (enq) begin
                        skid_q  <= i_d;
                        state_q <= StTwo;
                        ready_q <= 1'b0;
                    end else if (deq) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (deq) begin
                        main_q  <= skid_q;
                        state_q <= StOne;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    assign i_r    = ready_q;
    assign o_v    = (state_q != StEmpty);
    assign o_d    = main_q;
    assign o_drop = drop_q;

`ifdef BASE_AFILTER_REG_DROPCNT_EN
    logic [cntw-1:0] cnt_q;

    // A clear coinciding with a discard counts that discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (i_drop_clr) begin
            cnt_q <= dis ? cntw'(1) : '0;
        end else if (dis && (cnt_q != '1)) begin
            cnt_q <= cnt_q + cntw'(1);
        end
    end

    assign o_drop_cnt = cnt_q;
`else
    logic unused_drop_clr;

    assign unused_drop_clr = i_drop_clr;
    assign o_drop_cnt      = '0;
`endif

endmodule

// File: tb/tb_base_afilter_reg.sv
// Directed self-checking bench for base_afilter_reg; a second instance with cntw=2 covers
// counter saturation. Expected counter values follow BASE_AFILTER_REG_DROPCNT_EN.
module tb_base_afilter_reg;

    logic        clk;
    logic        reset;
    logic        i_v, i_r, i_en, o_v, o_r, o_drop, i_drop_clr;
    logic [0:7]  i_d, o_d;
    logic [15:0] o_drop_cnt;

    logic        s_v, s_r, s_en, s_ov, s_drop, s_clr;
    logic [0:7]  s_d, s_od;
    logic [1:0]  s_cnt;

    int ncmp  = 0;
    int nfail = 0;
    int drops = 0;

    base_afilter_reg #(.width(8), .cntw(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_v        (i_v),
        .i_r        (i_r),
        .i_d        (i_d),
        .i_en       (i_en),
        .o_v        (o_v),
        .o_r        (o_r),
        .o_d        (o_d),
        .o_drop     (o_drop),
        .i_drop_clr (i_drop_clr),
        .o_drop_cnt (o_drop_cnt)
    );

    base_afilter_reg #(.width(8), .cntw(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .i_v        (s_v),
        .i_r        (s_r),
        .i_d        (s_d),
        .i_en       (s_en),
        .o_v        (s_ov),
        .o_r        (1'b1),
        .o_d        (s_od),
        .o_drop     (s_drop),
        .i_drop_clr (s_clr),
        .o_drop_cnt (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(input int n, input int maxv);
`ifdef BASE_AFILTER_REG_DROPCNT_EN
        return (n > maxv) ? maxv : n;
`else
        return (n > maxv) ? 0 : 0;
`endif
    endfunction

    initial begin
        // 1: reset with a pending beat
        reset = 1'b1; i_v = 1'b1; i_d = 8'h55; i_en = 1'b1; o_r = 1'b1; i_drop_clr = 1'b0;
        s_v = 1'b0; s_d = 8'h00; s_en = 1'b0; s_clr = 1'b0;
        #2;
        check("rst_ir", 32'(i_r), 0);
        check("rst_ov", 32'(o_v), 0);
        check("rst_od", 32'(o_d), 0);
        check("rst_drop", 32'(o_drop), 0);
        check("rst_cnt", 32'(o_drop_cnt), 0);
        tick();
        tick();
        reset = 1'b0;
        check("rel_ir_before_clk", 32'(i_r), 0);
        tick();
        check("rel_ir", 32'(i_r), 1);
        check("rel_ov", 32'(o_v), 0);
        i_v = 1'b0;
        tick();
        check("rel_no_beat", 32'(o_v), 0);

        // 2: streaming at full throughput
        for (int k = 0; k < 8; k++) begin
            i_v = 1'b1; i_d = 8'(k + 1); i_en = 1'b1;
            tick();
            check("stream_ir", 32'(i_r), 1);
            check("stream_ov", 32'(o_v), 1);
            check("stream_od", 32'(o_d), 32'(k + 1));
        end
        i_v = 1'b0;
        tick();
        check("stream_drain", 32'(o_v), 0);

        // 3: backpressure fills the skid entry
        o_r = 1'b0; i_v = 1'b1; i_d = 8'hA1;
        tick();
        check("bp_ir1", 32'(i_r), 1);
        check("bp_od1", 32'(o_d), 32'hA1);
        i_d = 8'hA2;
        tick();
        check("bp_ir2", 32'(i_r), 0);
        check("bp_od2", 32'(o_d), 32'hA1);
        i_d = 8'hA3;
        tick();
        check("bp_hold_ir", 32'(i_r), 0);
        check("bp_hold_ov", 32'(o_v), 1);
        check("bp_hold_od", 32'(o_d), 32'hA1);
        tick();
        check("bp_stable_od", 32'(o_d), 32'hA1);
        o_r = 1'b1;
        tick();
        check("bp_out2", 32'(o_d), 32'hA2);
        check("bp_out2_ir", 32'(i_r), 1);
        tick();
        check("bp_out3", 32'(o_d), 32'hA3);
        check("bp_out3_ov", 32'(o_v), 1);
        i_v = 1'b0;
        tick();
        check("bp_drain", 32'(o_v), 0);

        // 4: alternating forward/discard
        for (int k = 0; k < 8; k++) begin
            i_v = 1'b1; i_d = 8'(8'h10 + k); i_en = ((k % 2) == 0);
            tick();
            check("mix_ir", 32'(i_r), 1);
            if ((k % 2) == 0) begin
                check("mix_ov", 32'(o_v), 1);
                check("mix_od", 32'(o_d), 32'(8'h10 + k));
            end else begin
                check("mix_ov_drop", 32'(o_v), 0);
            end
            if (o_drop) drops++;
        end
        i_v = 1'b0; i_en = 1'b1;
        tick();
        if (o_drop) drops++;
        check("mix_drops", 32'(drops), 4);
        check("mix_cnt", 32'(o_drop_cnt), cnt_exp(4, 65535));
        check("mix_idle_ov", 32'(o_v), 0);

        // 5: saturation with cntw=2
        for (int k = 0; k < 5; k++) begin
            s_v = 1'b1; s_en = 1'b0;
            tick();
            check("sat_cnt", 32'(s_cnt), cnt_exp(k + 1, 3));
            check("sat_ov", 32'(s_ov), 0);
        end
        s_clr = 1'b1;
        tick();
        check("sat_clr_drop", 32'(s_cnt), cnt_exp(1, 3));
        check("sat_pulse", 32'(s_drop), 1);
        s_v = 1'b0;
        tick();
        check("sat_clr_only", 32'(s_cnt), 0);
        check("sat_ir", 32'(s_r), 1);
        check("sat_od", 32'(s_od), 0);
        s_clr = 1'b0;

        // 6: reset while two beats are buffered
        o_r = 1'b0; i_v = 1'b1; i_en = 1'b1; i_d = 8'hB1;
        tick();
        i_d = 8'hB2;
        tick();
        check("two_ir", 32'(i_r), 0);
        check("two_od", 32'(o_d), 32'hB1);
        i_v = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_ov", 32'(o_v), 0);
        check("mid_rst_ir", 32'(i_r), 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ir", 32'(i_r), 1);
        check("post_rst_ov", 32'(o_v), 0);
        check("post_rst_cnt", 32'(o_drop_cnt), 0);
        o_r = 1'b1; i_v = 1'b1; i_d = 8'hC0;
        tick();
        check("c0_ov", 32'(o_v), 1);
        check("c0_od", 32'(o_d), 32'hC0);
        i_v = 1'b0;
        tick();
        check("c0_alone", 32'(o_v), 0);
        tick();
        check("c0_alone2", 32'(o_v), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/base_afilter_reg.md
Name: base_afilter_reg

Overview:
Registered valid/ready filter stage that carries data and qualifier together. Each accepted input beat is either buffered and forwarded (en=1) or consumed and discarded (en=0). A 2-entry skid buffer breaks the combinational ready path, so the stage can drop straight in front of a combinational filter or sink. An optional counter records discarded beats for debug registers.

Parameters:
width, 8, data payload width in bits
cntw, 16, width of the discarded-beat counter (active only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
i_v  input  1  input beat valid
i_r  output  1  input ready; registered, no combinational path from o_r
i_d  input  width  input payload [0:width-1]
i_en  input  1  qualifier sampled with the beat; 1=forward, 0=discard
o_v  output  1  output beat valid
o_r  input  1  output ready
o_d  output  width  output payload [0:width-1]
o_drop  output  1  registered one-cycle pulse, one cycle after a beat is discarded
i_drop_clr  input  1  synchronous clear of the drop counter
o_drop_cnt  output  cntw  saturating count of discarded beats

Behaviour:
- Clocking and reset: single clock. Reset is asynchronous and active-high.
- Reset values:
  - i_r=1 after reset release; i_r=0 while reset is asserted.
  - o_v=0, o_d=0, o_drop=0, o_drop_cnt=0.
  - Buffer state is EMPTY.
- Beat transfers:
  - Input transfer: i_v & i_r. Output transfer: o_v & o_r.
  - A transfer with i_en=1 enqueues i_d. A transfer with i_en=0 enqueues nothing, and o_drop pulses on the next cycle.
  - i_en is ignored when i_v=0.
- Buffer states: EMPTY (0 entries), ONE (main valid), TWO (main + skid valid).
  - o_v=1 in ONE or TWO. o_d always shows the main entry.
  - i_r = (state != TWO), from registered state only.
- State transitions ("enq" means a forwarded input transfer, "deq" means an output transfer):
  - EMPTY, enq -> ONE. Latency: data is visible on o_d the cycle after acceptance.
  - ONE, enq only -> TWO.
  - ONE, deq only -> EMPTY.
  - ONE, enq & deq -> ONE; main is reloaded with the new beat. This gives full throughput.
  - TWO, deq -> ONE; skid moves to main. No enq is possible in TWO.
  - All other cases hold state.
- Ordering and flow:
  - Forwarded beats leave in arrival order. None is duplicated or lost.
  - Dropped beats never appear on o_v.
  - Sustained traffic with o_r=1 runs at 1 beat/cycle.
  - A mix of forward and discard beats with o_r=1 never deasserts i_r.
- Stability: while o_v=1 and o_r=0, o_d and o_v hold stable.
- Simultaneous events:
  - A discard transfer in the same cycle as a deq is legal. Only the deq changes state.
  - i_drop_clr in the same cycle as a discard leaves the counter at 1.
- Counter: saturates at 2^cntw-1. A further discard at saturation holds the value.
- Reset mid-operation: buffered beats are lost, o_v falls immediately (asynchronously), and the counter clears.

Optional Feature:
Macro BASE_AFILTER_REG_DROPCNT_EN.
- Defined: o_drop_cnt is implemented as the saturating counter with i_drop_clr, as above.
- Undefined:
  - No counter flops are present. o_drop_cnt is tied to 0 and i_drop_clr is ignored.
  - o_drop and all datapath behaviour are unchanged.

Test Plan:
1. Reset with i_v=1 pending -> i_r=0 and o_v=0 during reset; i_r=1 on the first clock after release; no output beat appears.
2. Stream 0x01..0x08 with i_en=1 and o_r=1 -> o_d shows 0x01..0x08 on consecutive cycles, starting 1 cycle after the first acceptance; i_r stays 1.
3. o_r=0 while sending 0xA1, 0xA2, 0xA3 with i_en=1 -> 0xA1 and 0xA2 are accepted; i_r=0 after the second beat; 0xA3 is held off. Raising o_r yields 0xA1, 0xA2, 0xA3 in order with no gap.
4. Stream 0x10..0x17 with i_en=1,0,1,0,... and o_r=1 -> output is 0x10, 0x12, 0x14, 0x16 only; o_drop pulses 4 times; o_drop_cnt=4 (feature on) or 0 (feature off).
5. cntw=2, feature on: 5 discards -> o_drop_cnt saturates at 3. Then i_drop_clr together with a discard -> o_drop_cnt=1.
6. State TWO holding 0xB1, 0xB2; assert reset mid-stall -> o_v drops immediately. After release, a new beat 0xC0 emerges alone; 0xB1 and 0xB2 never appear.
